ras_stack: RTL and testbench
============================

// Module: ras_stack
// PURPOSE
//  Return address stack for the fetch predictor. Link-type branches push the
//  return PC38; RET-type branches pop it. ret_pc38 supplies the "ret_pc38"
//  next-PC choice in the fetch PC mux. Each request returns its stack index
//  and count for the checkpoint. A mispredict restores them with a
//  single-cycle pointer restore. Entry contents are never restored.
// PARAMETERS
//  RAS_ENTRIES      16   stack depth; must be a power of 2
//  LOG_RAS_ENTRIES  4    $clog2(RAS_ENTRIES); width of the stack index
//  PC_WIDTH         38   width of a stored return address (PC38_t)
// PORTS
//  CLK              in   1                  clock, all state rising-edge
//  RST              in   1                  asynchronous, active-high reset
//  req_valid        in   1                  fetch request this cycle
//  req_push         in   1                  push link address (JUMP_L/INDIRECT_L/RET_L)
//  req_pop          in   1                  pop top (RET/RET_L)
//  req_push_pc38    in   PC_WIDTH           return address to push
//  ret_pc38         out  PC_WIDTH           current top-of-stack return address
//  ras_index        out  LOG_RAS_ENTRIES    current stack pointer (next free slot)
//  ras_count        out  LOG_RAS_ENTRIES+1  valid entries, 0..RAS_ENTRIES
//  restore_valid    in   1                  mispredict restore of the pointers
//  restore_index    in   LOG_RAS_ENTRIES    stack pointer to restore
//  restore_count    in   LOG_RAS_ENTRIES+1  count to restore
// BEHAVIOUR
//  - State: array[RAS_ENTRIES] of PC_WIDTH, sp (LOG_RAS_ENTRIES), cnt (LOG_RAS_ENTRIES+1).
//  - Reset (async, RST=1): sp=0, cnt=0, every array entry = 38'h0.
//    Outputs during reset: ret_pc38=0, ras_index=0, ras_count=0.
//  - ret_pc38 = array[sp-1] (modulo RAS_ENTRIES), combinational from registered state.
//    When cnt==0, ret_pc38 still shows array[sp-1]; fetch treats it as a guess.
//  - ras_index = sp and ras_count = cnt, both from registered state. These are the
//    pre-update values; fetch checkpoints them with the request.
//  - All updates apply at the next rising edge. Priority: restore > request.
//  - restore_valid=1: sp<=restore_index; cnt<=restore_count. Any request that
//    cycle is dropped. The array is not modified.
//  - restore_count > RAS_ENTRIES is illegal. Behaviour is undefined; the bench asserts on it.
//  - req_valid=0: no change. Push/pop are ignored unless req_valid=1.
//  - Push only: array[sp]<=req_push_pc38; sp<=sp+1 (wraps 15->0);
//    cnt<=min(cnt+1, RAS_ENTRIES). When full, this overwrites the oldest entry and cnt stays 16.
//  - Pop only with cnt>0: sp<=sp-1 (wraps 0->15); cnt<=cnt-1. The array is unchanged.
//  - Pop only with cnt==0 (underflow): no state change.
//  - Push+pop together (RET_L): array[sp-1]<=req_push_pc38, replacing the top;
//    sp and cnt unchanged. This applies even when cnt==0; cnt stays 0.
//  - Width: sp arithmetic is mod 2^LOG_RAS_ENTRIES. cnt never exceeds
//    RAS_ENTRIES and never goes below 0.
//  - No handshake/backpressure: the block accepts a request every cycle. Latency:
//    an update is visible on ret_pc38/ras_index/ras_count 1 cycle after the request.
//  - RST asserted mid-sequence: immediate clear to reset values. It takes precedence
//    over a restore or request in the same cycle.
// TESTING
//  1 Reset: hold RST 3 cycles, then release -> ret_pc38=0, ras_index=0, ras_count=0.
//  2 Push 0x100, then push 0x200 -> ret=0x200, idx=2, cnt=2.
//    Pop -> ret=0x100, idx=1, cnt=1. Pop -> cnt=0, idx=0.
//  3 Overflow: push 0x1..0x11 (17 pushes) -> cnt=16, idx=1, ret=0x11.
//    Then 16 pops -> ret sequence 0x10..0x2, final cnt=0. 0x1 is lost.
//  4 Underflow: from reset, pop 3 times -> idx=0, cnt=0, ret=0 each cycle.
//  5 Push+pop: stack holding [0xA,0xB]; push 0xC together with pop ->
//    ret=0xC, idx=2, cnt=2. One pop -> ret=0xA.
//  6 Restore: after 5 pushes (idx=5, cnt=5), restore(idx=2, cnt=2) together with a
//    push of 0xF -> idx=2, cnt=2, ret=2nd pushed value, and 0xF is not written.
//    Then pulse RST mid-sequence -> all outputs return to 0 at once.

Source files
------------

// File: rtl/ras_stack.sv
// Return address stack for the fetch predictor: circular array with a
// next-free stack pointer and saturating entry count, restorable on mispredict.
module ras_stack #(
  parameter int RAS_ENTRIES     = 16,
  parameter int LOG_RAS_ENTRIES = 4,
  parameter int PC_WIDTH        = 38
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       req_valid,
  input  logic                       req_push,
  input  logic                       req_pop,
  input  logic [PC_WIDTH-1:0]        req_push_pc38,
  output logic [PC_WIDTH-1:0]        ret_pc38,
  output logic [LOG_RAS_ENTRIES-1:0] ras_index,
  output logic [LOG_RAS_ENTRIES:0]   ras_count,
  input  logic                       restore_valid,
  input  logic [LOG_RAS_ENTRIES-1:0] restore_index,
  input  logic [LOG_RAS_ENTRIES:0]   restore_count
);

  localparam logic [LOG_RAS_ENTRIES-1:0] SP_ONE   = LOG_RAS_ENTRIES'(1);
  localparam logic [LOG_RAS_ENTRIES:0]   CNT_ONE  = (LOG_RAS_ENTRIES+1)'(1);
  localparam logic [LOG_RAS_ENTRIES:0]   CNT_ZERO = '0;
  localparam logic [LOG_RAS_ENTRIES:0]   CNT_FULL = (LOG_RAS_ENTRIES+1)'(RAS_ENTRIES);

  logic [PC_WIDTH-1:0]        stack_q [RAS_ENTRIES];
  logic [LOG_RAS_ENTRIES-1:0] sp_q;
  logic [LOG_RAS_ENTRIES-1:0] sp_top;
  logic [LOG_RAS_ENTRIES:0]   cnt_q;

  // sp points at the next free slot, so the top lives one below it (wrapping).
  assign sp_top    = sp_q - SP_ONE;
  assign ret_pc38  = stack_q[sp_top];
  assign ras_index = sp_q;
  assign ras_count = cnt_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sp_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < RAS_ENTRIES; i++) begin
        stack_q[i] <= '0;
      end
    end else if (restore_valid) begin
      sp_q  <= restore_index;
      cnt_q <= restore_count;
    end else if (req_valid) begin
      if (req_push && req_pop) begin
        // RET_L replaces the top in place, even on an empty stack.
        stack_q[sp_top] <= req_push_pc38;
      end else if (req_push) begin
        stack_q[sp_q] <= req_push_pc38;
        sp_q          <= sp_q + SP_ONE;
        if (cnt_q != CNT_FULL) begin
          cnt_q <= cnt_q + CNT_ONE;
        end
      end else if (req_pop && (cnt_q != CNT_ZERO)) begin
        sp_q  <= sp_top;
        cnt_q <= cnt_q - CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_ras_stack.sv
// Self-checking bench for ras_stack: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a queue-free array model.
module tb_ras_stack;

  logic        CLK = 1'b0;
  logic        RST;
  logic        req_valid, req_push, req_pop;
  logic [37:0] req_push_pc38;
  logic [37:0] ret_pc38;
  logic [3:0]  ras_index;
  logic [4:0]  ras_count;
  logic        restore_valid;
  logic [3:0]  restore_index;
  logic [4:0]  restore_count;

  int total = 0;
  int bad   = 0;

  ras_stack dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_push(req_push), .req_pop(req_pop),
    .req_push_pc38(req_push_pc38),
    .ret_pc38(ret_pc38), .ras_index(ras_index), .ras_count(ras_count),
    .restore_valid(restore_valid), .restore_index(restore_index),
    .restore_count(restore_count)
  );

  always #5 CLK = ~CLK;

  // Reference model: plain integers, wrap by modulo arithmetic.
  logic [37:0] m_arr [16];
  int m_sp  = 0;
  int m_cnt = 0;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_sp = 0;
      m_cnt = 0;
      for (int i = 0; i < 16; i++) m_arr[i] = '0;
    end else if (restore_valid) begin
      m_sp  = int'(restore_index);
      m_cnt = int'(restore_count);
    end else if (req_valid) begin
      if (req_push && req_pop) begin
        m_arr[(m_sp + 15) % 16] = req_push_pc38;
      end else if (req_push) begin
        m_arr[m_sp] = req_push_pc38;
        m_sp = (m_sp + 1) % 16;
        if (m_cnt < 16) m_cnt = m_cnt + 1;
      end else if (req_pop && m_cnt > 0) begin
        m_sp = (m_sp + 15) % 16;
        m_cnt = m_cnt - 1;
      end
    end
  end

  always @(posedge CLK) begin
    if (!RST && restore_valid)
      assert (restore_count <= 5'd16) else $error("illegal restore_count %0d", restore_count);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    chk("model_ret", 64'(ret_pc38), 64'(m_arr[(m_sp + 15) % 16]));
    chk("model_idx", 64'(ras_index), 64'(m_sp));
    chk("model_cnt", 64'(ras_count), 64'(m_cnt));
  end

  task automatic idle();
    req_valid = 0; req_push = 0; req_pop = 0; req_push_pc38 = '0;
    restore_valid = 0; restore_index = '0; restore_count = '0;
  endtask

  task automatic step(input logic v, input logic pu, input logic po, input logic [37:0] pc,
                      input logic rv, input logic [3:0] ri, input logic [4:0] rc);
    req_valid = v; req_push = pu; req_pop = po; req_push_pc38 = pc;
    restore_valid = rv; restore_index = ri; restore_count = rc;
    @(posedge CLK);
    #1;
    idle();
  endtask

  task automatic push(input logic [37:0] pc);
    step(1, 1, 0, pc, 0, 4'd0, 5'd0);
  endtask

  task automatic pop();
    step(1, 0, 1, '0, 0, 4'd0, 5'd0);
  endtask

  task automatic expect3(input string nm, input logic [37:0] r, input logic [3:0] i, input logic [4:0] c);
    chk({nm, "_ret"}, 64'(ret_pc38), 64'(r));
    chk({nm, "_idx"}, 64'(ras_index), 64'(i));
    chk({nm, "_cnt"}, 64'(ras_count), 64'(c));
  endtask

  task automatic do_reset();
    RST = 1;
    repeat (3) @(posedge CLK);
    #1;
    RST = 0;
  endtask

  initial begin
    idle();
    do_reset();
    expect3("reset", 38'h0, 4'd0, 5'd0);

    push(38'h100);
    push(38'h200);
    expect3("push2", 38'h200, 4'd2, 5'd2);
    pop();
    expect3("pop1", 38'h100, 4'd1, 5'd1);
    pop();
    chk("pop2_idx", 64'(ras_index), 64'd0);
    chk("pop2_cnt", 64'(ras_count), 64'd0);

    do_reset();
    for (int k = 1; k <= 17; k++) push(38'(k));
    expect3("ovf", 38'h11, 4'd1, 5'd16);
    for (int k = 1; k <= 15; k++) begin
      pop();
      chk("ovf_pop_ret", 64'(ret_pc38), 64'(17 - k));
    end
    pop();
    chk("ovf_final_cnt", 64'(ras_count), 64'd0);

    do_reset();
    for (int k = 0; k < 3; k++) begin
      pop();
      expect3("udf", 38'h0, 4'd0, 5'd0);
    end

    do_reset();
    push(38'hA);
    push(38'hB);
    step(1, 1, 1, 38'hC, 0, 4'd0, 5'd0);
    expect3("pushpop", 38'hC, 4'd2, 5'd2);
    pop();
    chk("pushpop_pop_ret", 64'(ret_pc38), 64'hA);

    do_reset();
    for (int k = 1; k <= 5; k++) push(38'h50 + 38'(k));
    expect3("pre_restore", 38'h55, 4'd5, 5'd5);
    step(1, 1, 0, 38'hF, 1, 4'd2, 5'd2);
    expect3("restore", 38'h52, 4'd2, 5'd2);
    step(0, 0, 0, '0, 1, 4'd6, 5'd6);
    chk("restore_nowrite", 64'(ret_pc38), 64'h0);
    step(0, 0, 0, '0, 1, 4'd5, 5'd5);
    chk("restore_keep", 64'(ret_pc38), 64'h55);

    @(negedge CLK);
    #2;
    RST = 1;
    #1;
    expect3("midrst", 38'h0, 4'd0, 5'd0);
    req_valid = 1; req_push = 1; req_push_pc38 = 38'h77;
    restore_valid = 1; restore_index = 4'd9; restore_count = 5'd9;
    @(negedge CLK);
    expect3("midrst_hold", 38'h0, 4'd0, 5'd0);
    idle();
    RST = 0;

    for (int n = 0; n < 600; n++) begin
      @(negedge CLK);
      req_valid     = ($urandom_range(0, 3) != 0);
      req_push      = $urandom_range(0, 1) == 1;
      req_pop       = $urandom_range(0, 1) == 1;
      req_push_pc38 = {6'($urandom), 32'($urandom)};
      restore_valid = ($urandom_range(0, 15) == 0);
      restore_index = 4'($urandom);
      restore_count = 5'($urandom_range(0, 16));
    end
    @(negedge CLK);
    idle();
    repeat (2) @(negedge CLK);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
